// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if: byte intake, flow-control and status signals of the UART receive buffer
interface uart_rx_buffer_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH = 16
);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_data_valid;
  logic rx_error;
  logic echo_expect;
  logic flush;
  logic clear_flags;
  logic [DATA_BITS-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [$clog2(DEPTH):0] count;
  logic full;
  logic overflow;
  logic parity_err;
  modport master (
    output rx_data, rx_data_valid, rx_error, echo_expect, flush, clear_flags, out_ready,
    input out_data, out_valid, count, full, overflow, parity_err
  );
  modport slave (
    input rx_data, rx_data_valid, rx_error, echo_expect, flush, clear_flags, out_ready,
    output out_data, out_valid, count, full, overflow, parity_err
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: FWFT byte FIFO behind the UART receiver with echo skipping and sticky error flags
module uart_rx_buffer #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH = 16,
  parameter int SKIP_BITS = 8
) (
  input logic clk,
  input logic rst,
  uart_rx_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [SKIP_BITS-1:0] skip, skip_next;
  logic [SKIP_BITS:0] skip_sum;
  logic frame, echo_frame, push_req, push, pop, is_full, drop, overflow, parity_err;
  assign frame = bus.rx_data_valid | bus.rx_error;
  assign echo_frame = frame && skip != '0;
  assign push_req = bus.rx_data_valid && !bus.rx_error && skip == '0 && !bus.flush;
  assign is_full = cnt == CW'(DEPTH);
  assign pop = cnt != '0 && bus.out_ready;
  assign push = push_req && (!is_full || pop);
  assign drop = push_req && is_full && !pop;
  // Echo counter: add TX pulses, retire one per echoed frame, clamp at the top value
  always_comb begin
    skip_sum = {1'b0, skip} + (SKIP_BITS+1)'(bus.echo_expect) - (SKIP_BITS+1)'(echo_frame);
    skip_next = skip_sum[SKIP_BITS] ? '1 : skip_sum[SKIP_BITS-1:0];
  end
  // Pointers, occupancy and echo counter; flush behaves like a local reset of these
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      skip <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
      skip <= skip_next;
    end
  end
  // Storage array; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end
  // Sticky flags: a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overflow <= drop | (overflow & !bus.clear_flags);
      parity_err <= bus.rx_error | (parity_err & !bus.clear_flags);
    end
  end
  assign bus.out_valid = cnt != '0;
  assign bus.out_data = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.count = cnt;
  assign bus.full = is_full;
  assign bus.overflow = overflow;
  assign bus.parity_err = parity_err;
endmodule
